// File: rtl/core_l1i_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : core_l1i_pkg
//  Purpose : Shared constants for the L1 instruction cache: FSM state
//            encodings and helpers that locate the offset/index/tag fields
//            of a byte address for a given line and set geometry.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package core_l1i_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned WORD_LSB = 2;   // byte-within-word bits, ignored

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Lowest address bit of the set index.
  function automatic int unsigned idx_lsb(input int unsigned off_w);
    return WORD_LSB + off_w;
  endfunction

  // Lowest address bit of the tag.
  function automatic int unsigned tag_lsb(input int unsigned off_w,
                                          input int unsigned idx_w);
    return WORD_LSB + off_w + idx_w;
  endfunction

  // Number of tag bits left above offset and index.
  function automatic int unsigned tag_width(input int unsigned off_w,
                                            input int unsigned idx_w);
    return ADDR_W - tag_lsb(off_w, idx_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_l1i_cache_if.sv
`default_nettype none
// ============================================================================
//  Module  : core_l1i_cache_if
//  Purpose : Bundles the fetch-side request/response and the memory-side
//            refill signals of the L1 instruction cache.
//  Ports   : fetch  : l1i_addr_in, l1i_val_in, l1i_inv_in ->
//                     l1i_data_out, l1i_ack_out, l1i_stall_out
//            memory : mem_req_out, mem_addr_out -> mem_ack_in, mem_data_in
//            modport slave  = cache side, modport master = environment side
//  Rev     : 1.0  initial release
// ============================================================================
interface core_l1i_cache_if;

  logic [31:0] l1i_addr_in;
  logic        l1i_val_in;
  logic        l1i_inv_in;
  logic [31:0] l1i_data_out;
  logic        l1i_ack_out;
  logic        l1i_stall_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in;
  logic [31:0] mem_data_in;

  modport slave (
    input  l1i_addr_in, l1i_val_in, l1i_inv_in, mem_ack_in, mem_data_in,
    output l1i_data_out, l1i_ack_out, l1i_stall_out, mem_req_out, mem_addr_out
  );

  modport master (
    output l1i_addr_in, l1i_val_in, l1i_inv_in, mem_ack_in, mem_data_in,
    input  l1i_data_out, l1i_ack_out, l1i_stall_out, mem_req_out, mem_addr_out
  );

endinterface
`default_nettype wire

// File: rtl/core_l1i_array.sv
`default_nettype none
// ============================================================================
//  Module  : core_l1i_array
//  Purpose : Tag, data and valid storage of the direct-mapped L1I cache.
//            One asynchronous read port (lookup) and one synchronous write
//            port (refill). Valid bits clear on reset or on clear_all.
//  Ports   : clk, n_rst, clear_all
//            rd_idx, rd_off -> rd_data, rd_tag, rd_valid
//            wr_en, wr_idx, wr_off, wr_data     : data word write
//            tag_wr, tag_wr_data, valid_set     : tag write / valid set
//  Rev     : 1.0  initial release
// ============================================================================
module core_l1i_array #(
  parameter int OFF_W = 2,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_all,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             tag_wr,
  input  logic [TAG_W-1:0] tag_wr_data,
  input  logic             valid_set
);

  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = 1 << (IDX_W + OFF_W);

  logic [31:0]      r_data_mem [0:WORDS-1];
  logic [TAG_W-1:0] r_tag_mem  [0:SETS-1];
  logic [SETS-1:0]  r_valid;

  assign rd_data  = r_data_mem[{rd_idx, rd_off}];
  assign rd_tag   = r_tag_mem[rd_idx];
  assign rd_valid = r_valid[rd_idx];

  // Payload storage needs no reset: every lookup is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data_mem[{wr_idx, wr_off}] <= wr_data;
    end
    if (tag_wr) begin
      r_tag_mem[wr_idx] <= tag_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_valid <= '0;
    end else if (clear_all) begin
      r_valid <= '0;
    end else if (valid_set) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_l1i_cache.sv
`default_nettype none
// ============================================================================
//  Module  : core_l1i_cache
//  Purpose : Direct-mapped, read-only L1 instruction cache. Hits answer on
//            the next cycle; a miss stalls fetch, refills the whole line
//            word 0 upward, then answers the requested word in RESP.
//  Ports   : clk, n_rst (synchronous, active low)
//            bus (core_l1i_cache_if.slave): fetch request/response and
//            memory refill signals
//  Rev     : 1.0  initial release
// ============================================================================
module core_l1i_cache
  import core_l1i_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic                    clk,
  input  logic                    n_rst,
  core_l1i_cache_if.slave         bus
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = int'(tag_width(OFF_W, IDX_W));
  localparam int IDX_LSB = int'(idx_lsb(OFF_W));
  localparam int TAG_LSB = int'(tag_lsb(OFF_W, IDX_W));

  logic [1:0]       r_state;
  logic [OFF_W-1:0] r_beat;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic             r_inv_pend;
  logic [31:0]      r_resp_word;
  logic [31:0]      r_data_out;
  logic             r_ack;
  logic             r_stall;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_rd_data;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_valid;
  logic             w_hit;
  logic             w_beat_ack;
  logic             w_last_beat;
  logic             w_inv_any;
  logic             w_clear_all;
  logic             w_unused_addr;

  assign w_off = bus.l1i_addr_in[IDX_LSB-1:WORD_LSB];
  assign w_idx = bus.l1i_addr_in[TAG_LSB-1:IDX_LSB];
  assign w_tag = bus.l1i_addr_in[31:TAG_LSB];
  assign w_unused_addr = &{1'b0, bus.l1i_addr_in[WORD_LSB-1:0]};

  assign w_hit       = bus.l1i_val_in && w_rd_valid && (w_rd_tag == w_tag);
  assign w_beat_ack  = (r_state == ST_REFILL) && bus.mem_ack_in;
  assign w_last_beat = w_beat_ack && (r_beat == OFF_W'(LINE_WORDS - 1));
  // An invalidate arriving on the final beat must also suppress that line.
  assign w_inv_any   = r_inv_pend || bus.l1i_inv_in;
  // Deferred invalidates are flushed as the FSM returns to IDLE.
  assign w_clear_all = ((r_state == ST_IDLE) && bus.l1i_inv_in) ||
                       ((r_state == ST_RESP) && w_inv_any);

  core_l1i_array #(
    .OFF_W (OFF_W),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_all   (w_clear_all),
    .rd_idx      (w_idx),
    .rd_off      (w_off),
    .rd_data     (w_rd_data),
    .rd_tag      (w_rd_tag),
    .rd_valid    (w_rd_valid),
    .wr_en       (w_beat_ack),
    .wr_idx      (r_idx),
    .wr_off      (r_beat),
    .wr_data     (bus.mem_data_in),
    .tag_wr      (w_last_beat),
    .tag_wr_data (r_tag),
    .valid_set   (w_last_beat && !w_inv_any)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_inv_pend  <= 1'b0;
      r_resp_word <= '0;
      r_data_out  <= '0;
      r_ack       <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (bus.l1i_val_in) begin
            if (w_hit) begin
              r_ack      <= 1'b1;
              r_data_out <= w_rd_data;
            end else begin
              r_state <= ST_REFILL;
              r_stall <= 1'b1;
              r_tag   <= w_tag;
              r_idx   <= w_idx;
              r_off   <= w_off;
              r_beat  <= '0;
            end
          end
        end
        ST_REFILL: begin
          if (bus.l1i_inv_in) begin
            r_inv_pend <= 1'b1;
          end
          if (w_beat_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (r_beat == r_off) begin
              r_resp_word <= bus.mem_data_in;
            end
            if (w_last_beat) begin
              r_state    <= ST_RESP;
              r_stall    <= 1'b0;
              r_ack      <= 1'b1;
              // Requested word may be the one arriving on this very beat.
              r_data_out <= (r_beat == r_off) ? bus.mem_data_in : r_resp_word;
            end
          end
        end
        ST_RESP: begin
          r_ack      <= 1'b0;
          r_inv_pend <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.l1i_data_out  = r_data_out;
  assign bus.l1i_ack_out   = r_ack;
  assign bus.l1i_stall_out = r_stall;
  assign bus.mem_req_out   = (r_state == ST_REFILL);
  assign bus.mem_addr_out  = (r_state == ST_REFILL) ?
                             {r_tag, r_idx, r_beat, 2'b00} : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_core_l1i_cache.sv
`default_nettype none
// ============================================================================
//  Module  : tb_core_l1i_cache
//  Purpose : Self-checking bench for core_l1i_cache: reset state, cold miss,
//            warm hits, conflict eviction, invalidates and reset mid-refill.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_core_l1i_cache;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  core_l1i_cache_if bus ();

  core_l1i_cache #(
    .LINE_WORDS (4),
    .SETS       (64)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int         total  = 0;
  int         passed = 0;
  logic [7:0] epoch  = 8'd0;

  // Memory image: word address plus a per-phase epoch in the top byte so a
  // stale line can never masquerade as a fresh refill.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60 + ({24'h0, epoch} << 24);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_data"},  bus.l1i_data_out, 32'h0);
    check({nm, "_ack"},   {31'h0, bus.l1i_ack_out}, 32'h0);
    check({nm, "_stall"}, {31'h0, bus.l1i_stall_out}, 32'h0);
    check({nm, "_req"},   {31'h0, bus.mem_req_out}, 32'h0);
    check({nm, "_maddr"}, bus.mem_addr_out, 32'h0);
  endtask

  // Memory responder: one idle cycle after a request appears, then one ack
  // per cycle with data for the address currently presented.
  initial begin
    bit seen;
    seen = 1'b0;
    bus.mem_ack_in  = 1'b0;
    bus.mem_data_in = 32'h0;
    forever begin
      @(negedge clk);
      if (!bus.mem_req_out) begin
        seen = 1'b0;
        bus.mem_ack_in = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        bus.mem_ack_in = 1'b0;
      end else begin
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = mem_word(bus.mem_addr_out);
      end
    end
  end

  // Issue a request expected to miss; check stall length, refill address
  // order, returned word, then spend one idle cycle. inv_beat>=0 pulses the
  // invalidate while that beat's address is on the bus.
  task automatic run_miss(input logic [31:0] a, input int inv_beat,
                          input logic [31:0] exp, input string nm);
    logic [31:0] base;
    logic [31:0] last_a;
    int          stall_cnt;
    int          n_addr;
    bit          got;
    bit          inv_done;
    base      = {a[31:4], 4'h0};
    last_a    = 32'h0;
    stall_cnt = 0;
    n_addr    = 0;
    got       = 1'b0;
    inv_done  = 1'b0;
    bus.l1i_addr_in = a;
    bus.l1i_val_in  = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      bus.l1i_inv_in = 1'b0;
      if (bus.l1i_stall_out) stall_cnt++;
      if (bus.mem_req_out && (n_addr == 0 || bus.mem_addr_out != last_a)) begin
        if (n_addr < 4) check({nm, "_maddr"}, bus.mem_addr_out, base + 32'(4 * n_addr));
        last_a = bus.mem_addr_out;
        n_addr++;
      end
      if (inv_beat >= 0 && !inv_done && bus.mem_req_out &&
          bus.mem_addr_out == base + 32'(4 * inv_beat)) begin
        bus.l1i_inv_in = 1'b1;
        inv_done = 1'b1;
      end
      if (bus.l1i_ack_out) begin
        got = 1'b1;
        check({nm, "_data"}, bus.l1i_data_out, exp);
        check({nm, "_stall_resp"}, {31'h0, bus.l1i_stall_out}, 32'h0);
      end
    end
    if (!got) fail_now(nm);
    check({nm, "_stall_cycles"}, 32'(stall_cnt), 32'd5);
    check({nm, "_beats"}, 32'(n_addr), 32'd4);
    bus.l1i_val_in = 1'b0;
    bus.l1i_inv_in = 1'b0;
    @(negedge clk);
    check({nm, "_idle_ack"}, {31'h0, bus.l1i_ack_out}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        val;
    logic        exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit hit;
    vecs[0] = '{32'h104, 1'b1, 1'b1, 32'hA1};
    vecs[1] = '{32'h108, 1'b1, 1'b1, 32'hA2};
    vecs[2] = '{32'h10C, 1'b1, 1'b1, 32'hA3};
    vecs[3] = '{32'h100, 1'b0, 1'b0, 32'hA3};  // idle: data holds
    vecs[4] = '{32'h100, 1'b1, 1'b1, 32'hA0};
    vecs[5] = '{32'h103, 1'b1, 1'b1, 32'hA0};  // byte bits ignored

    bus.l1i_addr_in = 32'h0;
    bus.l1i_val_in  = 1'b0;
    bus.l1i_inv_in  = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Cold miss
    run_miss(32'h100, -1, 32'hA0, "cold");

    // Warm hits from the vector table
    for (int i = 0; i < 6; i++) begin
      bus.l1i_addr_in = vecs[i].addr;
      bus.l1i_val_in  = vecs[i].val;
      @(negedge clk);
      check($sformatf("hit%0d_ack", i), {31'h0, bus.l1i_ack_out}, {31'h0, vecs[i].exp_ack});
      check($sformatf("hit%0d_data", i), bus.l1i_data_out, vecs[i].exp_data);
      check($sformatf("hit%0d_stall", i), {31'h0, bus.l1i_stall_out}, 32'h0);
      check($sformatf("hit%0d_req", i), {31'h0, bus.mem_req_out}, 32'h0);
    end
    bus.l1i_val_in = 1'b0;
    @(negedge clk);

    // Conflict eviction on index 16
    epoch = 8'd1;
    run_miss(32'h500, -1, 32'h010001A0, "evict500");
    run_miss(32'h100, -1, 32'h010000A0, "evict100");

    // Invalidate in IDLE: same-cycle lookup sees the pre-clear state
    bus.l1i_addr_in = 32'h104;
    bus.l1i_val_in  = 1'b1;
    bus.l1i_inv_in  = 1'b1;
    @(negedge clk);
    bus.l1i_inv_in  = 1'b0;
    bus.l1i_val_in  = 1'b0;
    check("inv_same_ack", {31'h0, bus.l1i_ack_out}, 32'h1);
    check("inv_same_data", bus.l1i_data_out, 32'h010000A1);
    @(negedge clk);
    epoch = 8'd2;
    run_miss(32'h104, -1, 32'h020000A1, "inv_idle");

    // Invalidate during refill of line 0x200
    epoch = 8'd3;
    run_miss(32'h208, 1, 32'h030000E2, "inv_refill");
    run_miss(32'h208, -1, 32'h030000E2, "inv_refill_again");
    run_miss(32'h104, -1, 32'h030000A1, "inv_flushed_all");

    // Reset mid-refill once two beats have completed
    epoch = 8'd4;
    bus.l1i_addr_in = 32'h30C;
    bus.l1i_val_in  = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (bus.mem_req_out && bus.mem_addr_out == 32'h308) hit = 1'b1;
    end
    if (!hit) fail_now("midrst_wait");
    n_rst = 1'b0;
    bus.l1i_val_in = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    n_rst = 1'b1;
    @(negedge clk);
    run_miss(32'h30C, -1, 32'h04000123, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_l1i_cache.md
Name: core_l1i_cache

Overview:
Level-1 instruction cache that responds to the fetch stage's address/valid request and returns the instruction word. The cache is direct-mapped and read-only. It sits between the fetch stage and the memory arbiter. On a miss it refills a whole line from memory, one word per beat, and stalls the pipeline through the fetch-enable path until the word is returned.

Parameters:
LINE_WORDS, 4, words per cache line (power of 2, ≥2)
SETS, 64, number of lines (power of 2)
Derived (localparams, not overridable):
- OFF_W = log2(LINE_WORDS)
- IDX_W = log2(SETS)
- TAG_W = 30 - OFF_W - IDX_W

Ports:
clk  in  1  clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset
l1i_addr_in  in  32  fetch address from fetch stage; bits [1:0] ignored
l1i_val_in  in  1  fetch request valid
l1i_inv_in  in  1  invalidate-all request (fence.i), single-cycle pulse
l1i_data_out  out  32  instruction word
l1i_ack_out  out  1  l1i_data_out valid this cycle
l1i_stall_out  out  1  cache busy; fetch stage must hold its address and deassert its enable
mem_req_out  out  1  refill word request
mem_addr_out  out  32  word address of current refill beat
mem_ack_in  in  1  mem_data_in valid; one word per ack
mem_data_in  in  32  refill data

Behaviour:
- Address split: offset = addr[OFF_W+1:2], index = addr[OFF_W+IDX_W+1:OFF_W+2], tag = addr[31:OFF_W+IDX_W+2].
- Storage: data array SETS*LINE_WORDS x 32, tag array SETS x TAG_W, valid vector SETS x 1.
- Reset (n_rst=0 at a clk edge):
  - valid vector cleared; state=IDLE; beat counter=0; inv_pend=0.
  - All outputs 0: l1i_data_out, l1i_ack_out, l1i_stall_out, mem_req_out, mem_addr_out.
  - Reset mid-refill abandons the refill; no valid bit is set.
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - Hit (l1i_val_in, valid[idx], tag match): l1i_data_out=word, l1i_ack_out=1 on the next cycle. Back-to-back hits give one ack per cycle.
  - Miss: next cycle l1i_stall_out=1, l1i_ack_out=0, state→REFILL. Latch tag, index and offset; beat counter=0.
- REFILL:
  - mem_req_out=1; mem_addr_out = {tag,index,beat,2'b00}, i.e. the line is fetched from word 0 upward.
  - Each mem_ack_in writes mem_data_in into data[index][beat] and increments beat.
  - On the ack with beat==LINE_WORDS-1:
    - write tag[index]; set valid[index]=1 unless inv_pend;
    - mem_req_out drops next cycle; state→RESP.
  - mem_ack_in outside REFILL is ignored.
- RESP (1 cycle):
  - l1i_data_out = latched requested word; l1i_ack_out=1; l1i_stall_out=0 from this cycle; state→IDLE.
  - The returned word is correct even when inv_pend suppressed the valid bit.
- l1i_stall_out is registered. It is high from the cycle after the miss is detected through the last REFILL cycle.
- l1i_val_in low in IDLE: l1i_ack_out=0; l1i_data_out holds its last value.
- Invalidate:
  - l1i_inv_in in IDLE clears the whole valid vector at that edge. A lookup in the same cycle is evaluated against the pre-clear state.
  - l1i_inv_in in REFILL/RESP sets inv_pend. The in-flight line is not marked valid. The full valid vector is cleared on entry to IDLE, then inv_pend=0.
- Miss miss-under-refill is impossible; requests are ignored while stalled.

Decomposition:
- Package core_l1i_pkg: state enum (IDLE/REFILL/RESP), and functions or constants for tag/index/offset extraction given the parameters.
- One natural sub-module: core_l1i_array. It holds the tag, data and valid storage, with a 1-read/1-write port, a synchronous clear-all input and a synchronous valid-bit clear on reset.
- FSM and address logic live in the top module.

Test Plan:
- Cold miss: reset, request 0x0000_0100; mem returns 0xA0,0xA1,0xA2,0xA3 for words 0x100..0x10C with one ack per cycle → stall high 5 cycles, mem_addr_out sequence 0x100,0x104,0x108,0x10C, then ack with data 0xA0.
- Warm hits: then request 0x104, 0x108, 0x10C back-to-back → acks on 3 consecutive cycles with 0xA1,0xA2,0xA3, stall never asserted, mem_req_out stays 0.
- Conflict eviction: access 0x100, then 0x500 (same index 16, different tag), then 0x100 → three refills; the final access returns the refilled 0x100 data.
- Invalidate in IDLE: after line 0x100 is valid, pulse l1i_inv_in, then request 0x100 → miss and refill.
- Invalidate during refill: pulse l1i_inv_in at beat 1 of a refill of 0x200 → requested word still acked correctly; the next access to 0x200 misses again.
- Reset mid-refill: drop n_rst after beat 2 → all outputs 0 next cycle; the next request to the same line misses and refills from beat 0.
